// File: rtl/bus_sram_slave.sv
// Word-addressed SRAM slave for the two-phase peripheral bus with WAIT_CYCLES wait states.
// Define BUS_SRAM_PROTOCOL_CHECK_EN to add the sticky protoError checker.
module bus_sram_slave #(
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        select,
  input  logic        enable,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        rangeError
`ifdef BUS_SRAM_PROTOCOL_CHECK_EN
  ,
  output logic        protoError
`endif
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            wr_q, wr_d, inr_q, inr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            ready_q, ready_d, rerr_q, rerr_d, rd_en_d;
  logic [31:0]     rdata_q;
  logic [32:0]     off;
  logic            start, we;
  logic [31:0]     mem [MEM_WORDS];

  // 33-bit offset: a borrow (addr < BASE_ADDR) lands above the window, as does a top-of-space wrap
  assign off   = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign start = select & enable;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    inr_d   = inr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: if (start) begin
        idx_d   = off[AW+1:2];
        wr_d    = write;
        wdata_d = wdata;
        inr_d   = off < 33'(4 * MEM_WORDS);
        cnt_d   = 4'(WAIT_CYCLES);
        state_d = (WAIT_CYCLES == 0) ? S_RESPOND : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // abort outranks expiry
        if (!select) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_RESPOND;
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_RESPOND);
    rerr_d  = ready_d & ~inr_d;
    rd_en_d = ready_d & ~wr_d & inr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      inr_q   <= 1'b0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      rerr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      inr_q   <= inr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      rerr_q  <= rerr_d;
      rdata_q <= rd_en_d ? mem[idx_d] : '0;
    end
  end

  // write lands on the edge closing RESPOND; a reset on that edge drops it
  assign we = (state_q == S_RESPOND) & wr_q & inr_q & ~rst;

  always_ff @(posedge clk) begin
    if (we) mem[idx_q] <= wdata_q;
  end

  assign ready      = ready_q;
  assign rdata      = rdata_q;
  assign rangeError = rerr_q;

`ifdef BUS_SRAM_PROTOCOL_CHECK_EN
  logic        proto_q, proto_d, setup_q, setup_d, last_ready_q, last_ready_d;
  logic [31:0] setup_addr_q, setup_addr_d, addr_q, addr_d;

  always_comb begin
    setup_d      = select & ~enable;
    setup_addr_d = addr;
    last_ready_d = ready_q;
    addr_d       = (state_q == S_IDLE && start) ? addr : addr_q;
    proto_d      = proto_q;
    if (enable & ~select) proto_d = 1'b1;
    if (state_q == S_IDLE && start && !(setup_q && setup_addr_q == addr)) proto_d = 1'b1;
    if (state_q == S_WAIT && select &&
        (addr != addr_q || write != wr_q || wdata != wdata_q)) proto_d = 1'b1;
    if (state_q == S_WAIT && !select) proto_d = 1'b1;
    if (last_ready_q && start) proto_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      proto_q      <= 1'b0;
      setup_q      <= 1'b0;
      setup_addr_q <= '0;
      last_ready_q <= 1'b0;
      addr_q       <= '0;
    end else begin
      proto_q      <= proto_d;
      setup_q      <= setup_d;
      setup_addr_q <= setup_addr_d;
      last_ready_q <= last_ready_d;
      addr_q       <= addr_d;
    end
  end

  assign protoError = proto_q;
`endif
endmodule

// File: tb/tb_bus_sram_slave.sv
// Directed bench for bus_sram_slave: instance A (WAIT_CYCLES=2) and instance B (WAIT_CYCLES=0).
module tb_bus_sram_slave;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic        write = 1'b0, sel_a = 1'b0, en_a = 1'b0, sel_b = 1'b0, en_b = 1'b0;
  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, rerr_a, rerr_b;
`ifdef BUS_SRAM_PROTOCOL_CHECK_EN
  logic        perr_a, perr_b;
`endif
  int          n_tests = 0, n_fail = 0;
  logic [31:0] rd;
  logic        re, seen;
  int          lat;

  always #5 clk = ~clk;

  bus_sram_slave #(.MEM_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut_a (
    .clk(clk), .rst(rst), .addr(addr), .select(sel_a), .enable(en_a), .write(write),
    .wdata(wdata), .rdata(rdata_a), .ready(ready_a), .rangeError(rerr_a)
`ifdef BUS_SRAM_PROTOCOL_CHECK_EN
    , .protoError(perr_a)
`endif
  );

  bus_sram_slave #(.MEM_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_b (
    .clk(clk), .rst(rst), .addr(addr), .select(sel_b), .enable(en_b), .write(write),
    .wdata(wdata), .rdata(rdata_b), .ready(ready_b), .rangeError(rerr_b)
`ifdef BUS_SRAM_PROTOCOL_CHECK_EN
    , .protoError(perr_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transfer; lat counts cycles from setup to ready (-1 on timeout).
  task automatic xfer(input bit b, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] a_wait, output logic [31:0] r, output logic e,
                      output int l);
    l = -1; r = '0; e = 1'b0;
    @(negedge clk);
    addr = a; wdata = d; write = wr;
    if (b) sel_b = 1'b1; else sel_a = 1'b1;
    @(negedge clk);
    if (b) en_b = 1'b1; else en_a = 1'b1;
    for (int k = 2; k < 20; k++) begin
      @(negedge clk);
      if (k == 2) addr = a_wait;
      if (b ? ready_b : ready_a) begin
        l = k;
        r = b ? rdata_b : rdata_a;
        e = b ? rerr_b : rerr_a;
        break;
      end
    end
    sel_a = 1'b0; en_a = 1'b0; sel_b = 1'b0; en_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr_chk(input string tag, input bit b, input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input logic exp_err);
    logic [31:0] r; logic e; int l;
    xfer(b, 1'b1, a, d, a, r, e, l);
    check({tag, "_lat"}, 32'(l), 32'(exp_lat));
    check({tag, "_rerr"}, 32'(e), 32'(exp_err));
  endtask

  task automatic rd_chk(input string tag, input bit b, input logic [31:0] a,
                        input logic [31:0] exp_d, input int exp_lat, input logic exp_err);
    logic [31:0] r; logic e; int l;
    xfer(b, 1'b0, a, 32'h0, a, r, e, l);
    check({tag, "_lat"}, 32'(l), 32'(exp_lat));
    check({tag, "_data"}, r, exp_d);
    check({tag, "_rerr"}, 32'(e), 32'(exp_err));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready_a", 32'(ready_a), 32'd0);
    check("rst_rdata_a", rdata_a, 32'h0);
    check("rst_rerr_a", 32'(rerr_a), 32'd0);
    check("rst_ready_b", 32'(ready_b), 32'd0);
`ifdef BUS_SRAM_PROTOCOL_CHECK_EN
    check("rst_proto_a", 32'(perr_a), 32'd0);
`endif
    rst = 1'b0;

    wr_chk("wr10", 1'b0, 32'h10, 32'hDEAD_BEEF, 4, 1'b0);
    rd_chk("rd10", 1'b0, 32'h10, 32'hDEAD_BEEF, 4, 1'b0);
    wr_chk("b_wr0", 1'b1, 32'h0, 32'h1234_5678, 2, 1'b0);
    rd_chk("b_rd0", 1'b1, 32'h0, 32'h1234_5678, 2, 1'b0);

    wr_chk("wr0", 1'b0, 32'h0, 32'h0000_1111, 4, 1'b0);
    wr_chk("wr_oor", 1'b0, 32'h1000, 32'hFFFF_FFFF, 4, 1'b1);
    rd_chk("rd_oor", 1'b0, 32'h1000, 32'h0, 4, 1'b1);
    rd_chk("rd0_kept", 1'b0, 32'h0, 32'h0000_1111, 4, 1'b0);
    wr_chk("wr_last", 1'b0, 32'hFFC, 32'hCAFE_F00D, 4, 1'b0);
    rd_chk("rd_last", 1'b0, 32'hFFC, 32'hCAFE_F00D, 4, 1'b0);
`ifdef BUS_SRAM_PROTOCOL_CHECK_EN
    check("proto_clean", 32'(perr_a), 32'd0);
`endif

    // abort in the cycle the counter hits 1
    wr_chk("wr20", 1'b0, 32'h20, 32'h2020_2020, 4, 1'b0);
    @(negedge clk);
    addr = 32'h20; wdata = 32'hA5A5_A5A5; write = 1'b1; sel_a = 1'b1;
    @(negedge clk); en_a = 1'b1;
    seen = 1'b0;
    @(negedge clk); seen |= ready_a;
    @(negedge clk); seen |= ready_a; sel_a = 1'b0; en_a = 1'b0;
    repeat (6) begin @(negedge clk); seen |= ready_a; end
    check("abort_no_ready", 32'(seen), 32'd0);
    rd_chk("rd20_old", 1'b0, 32'h20, 32'h2020_2020, 4, 1'b0);
`ifdef BUS_SRAM_PROTOCOL_CHECK_EN
    check("proto_abort", 32'(perr_a), 32'd1);
`endif

    // reset while a write sits in WAIT
    wr_chk("wr40", 1'b0, 32'h40, 32'h4040_4040, 4, 1'b0);
    @(negedge clk);
    addr = 32'h40; wdata = 32'h0000_0BAD; write = 1'b1; sel_a = 1'b1;
    @(negedge clk); en_a = 1'b1;
    @(negedge clk); rst = 1'b1; sel_a = 1'b0; en_a = 1'b0;
    seen = 1'b0;
    repeat (2) begin @(negedge clk); seen |= ready_a; end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); seen |= ready_a; end
    check("rst_mid_ready", 32'(seen), 32'd0);
    check("rst_mid_rdata", rdata_a, 32'h0);
`ifdef BUS_SRAM_PROTOCOL_CHECK_EN
    check("proto_cleared", 32'(perr_a), 32'd0);
`endif
    rd_chk("rd40_old", 1'b0, 32'h40, 32'h4040_4040, 4, 1'b0);

    // addr changes during WAIT: transfer still uses the latched address
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 32'h14, rd, re, lat);
    check("chg_lat", 32'(lat), 32'd4);
    check("chg_data", rd, 32'hDEAD_BEEF);
`ifdef BUS_SRAM_PROTOCOL_CHECK_EN
    check("proto_chg", 32'(perr_a), 32'd1);
    rd_chk("rd10_again", 1'b0, 32'h10, 32'hDEAD_BEEF, 4, 1'b0);
    check("proto_sticky", 32'(perr_a), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("proto_rst", 32'(perr_a), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
